// File: rtl/gf180mcu_fd_sc_mcu9t5v0_addh_counter_pkg.sv
// Shared constants for the addh-based registered up-counter.
// Mode encodings and legal width range.
package gf180mcu_fd_sc_mcu9t5v0_addh_counter_pkg;

    localparam int CNT_MODE_WRAP = 0;
    localparam int CNT_MODE_SAT  = 1;

    localparam int CNT_WIDTH_MIN = 2;
    localparam int CNT_WIDTH_MAX = 32;

    function automatic bit cnt_width_ok(input int w);
        return (w >= CNT_WIDTH_MIN) && (w <= CNT_WIDTH_MAX);
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0_addh_inc.sv
// Half-adder cell model and the ripple incrementer built from it.
// Carry-in is the count enable, so a disabled chain passes A through.
module gf180mcu_fd_sc_mcu9t5v0_addh_func (
`ifdef USE_POWER_PINS
    inout  wire  VDD,
    inout  wire  VSS,
`endif
    input  logic A,
    input  logic B,
    output logic S,
    output logic CO
);

    assign S  = A ^ B;
    assign CO = A & B;

endmodule

module gf180mcu_fd_sc_mcu9t5v0_addh_inc #(
    parameter int WIDTH = 4
) (
`ifdef USE_POWER_PINS
    inout  wire              VDD,
    inout  wire              VSS,
`endif
    input  logic [WIDTH-1:0] A,
    input  logic             CI,
    output logic [WIDTH-1:0] S,
    output logic             CO
);

    logic [WIDTH:0] carry;

    assign carry[0] = CI;

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        gf180mcu_fd_sc_mcu9t5v0_addh_func u_addh (
`ifdef USE_POWER_PINS
            .VDD (VDD),
            .VSS (VSS),
`endif
            .A   (A[i]),
            .B   (carry[i]),
            .S   (S[i]),
            .CO  (carry[i+1])
        );
    end

    assign CO = carry[WIDTH];

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0_addh_counter.sv
// Registered up-counter: addh incrementer feeding a DFF bank, with
// clear, load, enable, wrap/saturate, terminal count and sticky overflow.
module gf180mcu_fd_sc_mcu9t5v0_addh_counter
    import gf180mcu_fd_sc_mcu9t5v0_addh_counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int SATURATE = CNT_MODE_WRAP
) (
`ifdef USE_POWER_PINS
    inout  wire              VDD,
    inout  wire              VSS,
`endif
    input  logic             CLK,
    input  logic             RN,
    input  logic             CLR,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
    input  logic             EN,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             CO,
    output logic             OVF
);

    if (!cnt_width_ok(WIDTH)) begin : g_bad_width
        $error("addh_counter: WIDTH out of range");
    end

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] sum;
    logic             wrap;
    logic             tc_r;
    logic             co_r;
    logic             ovf_r;
    logic             co_next;
    logic             ovf_next;
    logic             tc_next;

    gf180mcu_fd_sc_mcu9t5v0_addh_inc #(
        .WIDTH (WIDTH)
    ) u_inc (
`ifdef USE_POWER_PINS
        .VDD (VDD),
        .VSS (VSS),
`endif
        .A   (q_r),
        .CI  (EN),
        .S   (sum),
        .CO  (wrap)
    );

    // Chain carry-out only fires when EN is high and Q is all-ones.
    always_comb begin
        q_next   = q_r;
        co_next  = 1'b0;
        ovf_next = ovf_r;
        if (CLR) begin
            q_next   = '0;
            ovf_next = 1'b0;
        end else if (LD) begin
            q_next = D;
        end else if (wrap) begin
            co_next  = 1'b1;
            ovf_next = 1'b1;
            q_next   = (SATURATE == CNT_MODE_SAT) ? q_r : sum;
        end else begin
            q_next = sum;
        end
        tc_next = &q_next;
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            q_r   <= '0;
            tc_r  <= 1'b0;
            co_r  <= 1'b0;
            ovf_r <= 1'b0;
        end else begin
            q_r   <= q_next;
            tc_r  <= tc_next;
            co_r  <= co_next;
            ovf_r <= ovf_next;
        end
    end

    assign Q   = q_r;
    assign TC  = tc_r;
    assign CO  = co_r;
    assign OVF = ovf_r;

`ifndef FUNCTIONAL
    specify
        (CLK => Q)   = (1.0, 1.0);
        (CLK => TC)  = (1.0, 1.0);
        (CLK => CO)  = (1.0, 1.0);
        (CLK => OVF) = (1.0, 1.0);
        (negedge RN => (Q +: 1'b0))   = (1.0, 1.0);
        (negedge RN => (TC +: 1'b0))  = (1.0, 1.0);
        (negedge RN => (CO +: 1'b0))  = (1.0, 1.0);
        (negedge RN => (OVF +: 1'b0)) = (1.0, 1.0);
        $setuphold(posedge CLK, CLR, 0.0, 0.0);
        $setuphold(posedge CLK, LD, 0.0, 0.0);
        $setuphold(posedge CLK, D, 0.0, 0.0);
        $setuphold(posedge CLK, EN, 0.0, 0.0);
    endspecify
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0_addh_counter.sv
// Scoreboard bench: three counters (4b wrap, 4b saturate, 32b wrap).
// Stimulus queues expected values; a negedge monitor pops and compares.
module tb_gf180mcu_fd_sc_mcu9t5v0_addh_counter;

    logic        clk = 1'b0;
    logic        rn;
    logic [2:0]  clr;
    logic [2:0]  ld;
    logic [2:0]  en;
    logic [31:0] d;
    logic [3:0]  q0;
    logic [3:0]  q1;
    logic [31:0] q2;
    logic [2:0]  tc;
    logic [2:0]  co;
    logic [2:0]  ovf;

    always #5 clk = ~clk;

    gf180mcu_fd_sc_mcu9t5v0_addh_counter #(.WIDTH(4), .SATURATE(0)) dut_wrap (
        .CLK(clk), .RN(rn), .CLR(clr[0]), .LD(ld[0]), .D(d[3:0]), .EN(en[0]),
        .Q(q0), .TC(tc[0]), .CO(co[0]), .OVF(ovf[0])
    );

    gf180mcu_fd_sc_mcu9t5v0_addh_counter #(.WIDTH(4), .SATURATE(1)) dut_sat (
        .CLK(clk), .RN(rn), .CLR(clr[1]), .LD(ld[1]), .D(d[3:0]), .EN(en[1]),
        .Q(q1), .TC(tc[1]), .CO(co[1]), .OVF(ovf[1])
    );

    gf180mcu_fd_sc_mcu9t5v0_addh_counter #(.WIDTH(32), .SATURATE(0)) dut_w32 (
        .CLK(clk), .RN(rn), .CLR(clr[2]), .LD(ld[2]), .D(d), .EN(en[2]),
        .Q(q2), .TC(tc[2]), .CO(co[2]), .OVF(ovf[2])
    );

    typedef struct {
        int          id;
        logic [31:0] q;
        logic        tc;
        logic        co;
        logic        ovf;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] q_of(int id);
        if (id == 0) return {28'b0, q0};
        if (id == 1) return {28'b0, q1};
        return q2;
    endfunction

    task automatic step(int id, logic c, logic l, logic [31:0] dv, logic e,
                        logic [31:0] xq, logic xtc, logic xco, logic xovf,
                        string name);
        exp_t x;
        clr = '0;
        ld = '0;
        en = '0;
        clr[id] = c;
        ld[id] = l;
        en[id] = e;
        d = dv;
        @(posedge clk);
        x = '{id, xq, xtc, xco, xovf, name};
        sb.push_back(x);
        #1;
    endtask

    task automatic idle();
        clr = '0;
        ld = '0;
        en = '0;
        d = '0;
    endtask

    // Monitor: outputs are registered, so one entry per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.name, ".q"},   q_of(e.id),         e.q);
                check({e.name, ".tc"},  {31'b0, tc[e.id]},  {31'b0, e.tc});
                check({e.name, ".co"},  {31'b0, co[e.id]},  {31'b0, e.co});
                check({e.name, ".ovf"}, {31'b0, ovf[e.id]}, {31'b0, e.ovf});
            end
        end
    end

    initial begin
        logic [31:0] m;
        logic        mc;
        logic        mo;
        logic        c;
        logic        l;
        logic        e;
        logic [31:0] dv;

        rn = 1'b0;
        idle();
        #1;
        check("rst.q0", {28'b0, q0}, 32'h0);
        check("rst.q2", q2, 32'h0);
        check("rst.flags", {23'b0, tc, co, ovf}, 32'h0);
        @(negedge clk);
        rn = 1'b1;
        @(posedge clk);
        #1;

        // Async reset mid-count, no clock edge involved.
        step(0, 0, 1, 32'h9, 0, 32'h9, 0, 0, 0, "ld9");
        @(negedge clk);
        #1;
        rn = 1'b0;
        #1;
        check("async.q", {28'b0, q0}, 32'h0);
        check("async.flags", {29'b0, tc[0], co[0], ovf[0]}, 32'h0);
        #1;
        rn = 1'b1;
        for (int i = 1; i <= 3; i++)
            step(0, 0, 0, 0, 1, i, 0, 0, 0, "post_rst");

        // Wrap mode, 17 enabled edges from zero.
        step(0, 1, 0, 0, 0, 32'h0, 0, 0, 0, "clr");
        for (int i = 1; i <= 17; i++)
            step(0, 0, 0, 0, 1, i % 16, (i == 15), (i == 16), (i >= 16),
                 "wrap_run");
        step(0, 0, 0, 0, 0, 32'h1, 0, 0, 1, "wrap_hold");

        // Load beats enable in the same cycle.
        step(0, 0, 1, 32'hA, 1, 32'hA, 0, 0, 1, "ld_en");
        step(0, 0, 0, 0, 1, 32'hB, 0, 0, 1, "ld_next");

        // Clear beats load and clears overflow.
        step(0, 1, 1, 32'h7, 0, 32'h0, 0, 0, 0, "clr_ld");
        for (int i = 0; i < 5; i++)
            step(0, 0, 0, 0, 0, 32'h0, 0, 0, 0, "idle0");

        step(0, 0, 1, 32'hF, 0, 32'hF, 1, 0, 0, "ld_ones");
        step(0, 0, 0, 0, 1, 32'h0, 0, 1, 1, "ld_ones_wrap");
        step(0, 0, 0, 0, 1, 32'h1, 0, 0, 1, "after_wrap");

        // Saturate mode.
        step(1, 0, 1, 32'hD, 0, 32'hD, 0, 0, 0, "sat_ld");
        step(1, 0, 0, 0, 1, 32'hE, 0, 0, 0, "sat_e");
        step(1, 0, 0, 0, 1, 32'hF, 1, 0, 0, "sat_f");
        step(1, 0, 0, 0, 1, 32'hF, 1, 1, 1, "sat_hold1");
        step(1, 0, 0, 0, 1, 32'hF, 1, 1, 1, "sat_hold2");
        step(1, 0, 0, 0, 0, 32'hF, 1, 0, 1, "sat_idle");

        // 32-bit boundary.
        step(2, 0, 1, 32'hFFFF_FFFE, 0, 32'hFFFF_FFFE, 0, 0, 0, "w32_ld");
        step(2, 0, 0, 0, 1, 32'hFFFF_FFFF, 1, 0, 0, "w32_tc");
        step(2, 0, 0, 0, 1, 32'h0, 0, 1, 1, "w32_wrap");

        // Random control sequence against a behavioural model.
        m = 32'h0;
        mc = 1'b1;
        mo = 1'b1;
        for (int i = 0; i < 60; i++) begin
            c = ($urandom_range(0, 9) == 0);
            l = ($urandom_range(0, 3) == 0);
            e = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1)
                dv = 32'hFFFF_FFFD + $urandom_range(0, 2);
            else
                dv = $urandom;
            if (c) begin
                m = 0;
                mo = 0;
                mc = 0;
            end else if (l) begin
                m = dv;
                mc = 0;
            end else if (e) begin
                if (m == 32'hFFFF_FFFF) begin
                    m = 0;
                    mc = 1;
                    mo = 1;
                end else begin
                    m = m + 1;
                    mc = 0;
                end
            end else begin
                mc = 0;
            end
            step(2, c, l, dv, e, m, (m == 32'hFFFF_FFFF), mc, mo, "rand32");
        end

        idle();
        repeat (3) @(negedge clk);
        #1;
        check("sb_drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
